// File: rtl/cycle_term.sv
// cycle_term: bus-cycle terminator for the 68030 playground boards.
// Turns active-low chip selects into a DSACK response after a per-channel
// wait count, at a per-channel port size, and runs a bus-error watchdog
// with a sticky status flag for cycles that nobody terminates.
module cycle_term #(
  parameter int                      NCHAN       = 4,
  parameter int                      WAIT_W      = 4,
  parameter logic [NCHAN*WAIT_W-1:0] CH_WAITS    = {NCHAN{4'd0}},
  parameter logic [NCHAN*2-1:0]      CH_PORT     = {NCHAN{2'b10}},
  parameter logic [NCHAN-1:0]        CH_NEEDS_DS = {NCHAN{1'b0}},
  parameter int                      BERR_W      = 7,
  parameter int                      BERR_TMO    = 64
) (
  input  logic             CPU_CLK,
  input  logic             nRST,
  input  logic             nAS,
  input  logic             nDS,
  input  logic [NCHAN-1:0] nSEL,
  input  logic             STERM_IN,
  input  logic             BERR_CLR,
  output logic [1:0]       DSACK,
  output logic             BERR,
  output logic             BERR_FLAG,
  output logic             BUSY
);

  localparam int CH_W = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_COUNT  = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [WAIT_W-1:0] CNT_ONE  = WAIT_W'(1);
  localparam logic [BERR_W-1:0] WDOG_ONE = BERR_W'(1);
  localparam logic [BERR_W-1:0] TMO_M1   = BERR_W'(BERR_TMO - 1);

  logic [1:0]        r_state;
  logic [CH_W-1:0]   r_ch;
  logic [WAIT_W-1:0] r_cnt;
  logic [1:0]        r_dsack;
  logic [BERR_W-1:0] r_wdog;
  logic              r_berr_flag;

  logic [WAIT_W-1:0] w_wait_tbl [NCHAN];
  logic [1:0]        w_port_tbl [NCHAN];
  logic              w_sel_any;
  logic [CH_W-1:0]   w_sel_idx;
  logic              w_sel_gated;
  logic              w_wdog_hold;
  logic [BERR_W-1:0] w_wdog_nxt;
  logic              w_wdog_hit;

  // Unpack the per-channel parameter vectors into indexable tables.
  for (genvar g = 0; g < NCHAN; g++) begin : g_tbl
    assign w_wait_tbl[g] = CH_WAITS[g*WAIT_W +: WAIT_W];
    assign w_port_tbl[g] = CH_PORT[g*2 +: 2];
  end

  // Lowest-numbered active select wins; scanning downward leaves it last.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can
    // leave it unassigned and infer a latch.
    w_sel_any = 1'b0;
    w_sel_idx = '0;
    for (int i = NCHAN - 1; i >= 0; i--) begin
      if (!nSEL[i]) begin
        w_sel_any = 1'b1;
        w_sel_idx = CH_W'(i);
      end
    end
  end

  // A DS-qualified channel waits in IDLE until the data strobe arrives; the
  // next-lower select is deliberately not considered in its place.
  assign w_sel_gated = CH_NEEDS_DS[w_sel_idx] & nDS;

  // Terminator FSM: capture a select, count its wait states, hold DSACK.
  always_ff @(posedge CPU_CLK or negedge nRST) begin
    if (!nRST) begin
      // NOTE: sequential state uses non-blocking assignments so every
      // register samples pre-edge values regardless of statement order.
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_cnt   <= '0;
      r_dsack <= 2'b00;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (!nAS && w_sel_any && !w_sel_gated) begin
            r_ch    <= w_sel_idx;
            r_cnt   <= w_wait_tbl[w_sel_idx];
            r_state <= S_COUNT;
          end
        end
        S_COUNT: begin
          if (nAS) begin
            r_dsack <= 2'b00;
            r_state <= S_IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_ONE;
          end else begin
            // Port 00 lands here with DSACK still 00: only BERR ends it.
            r_dsack <= w_port_tbl[r_ch];
            r_state <= S_FINISH;
          end
        end
        S_FINISH: begin
          if (nAS) begin
            r_dsack <= 2'b00;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_dsack <= 2'b00;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // The watchdog pauses while a real acknowledge is being held or while a
  // synchronous (STERM) cycle is in progress. A FINISH with port 00 carries
  // no acknowledge, so it keeps counting and eventually raises BERR.
  assign w_wdog_hold = ((r_state == S_FINISH) && (r_dsack != 2'b00)) | STERM_IN;

  // Next watchdog value: clear between cycles, saturate at the timeout.
  always_comb begin
    w_wdog_nxt = r_wdog;
    if (nAS) begin
      w_wdog_nxt = '0;
    end else if (!w_wdog_hold && (r_wdog != TMO_M1)) begin
      w_wdog_nxt = r_wdog + WDOG_ONE;
    end
  end

  assign w_wdog_hit = (w_wdog_nxt == TMO_M1) && (r_wdog != TMO_M1);

  // Watchdog counter and sticky timeout flag; a new timeout beats a clear.
  always_ff @(posedge CPU_CLK or negedge nRST) begin
    if (!nRST) begin
      r_wdog      <= '0;
      r_berr_flag <= 1'b0;
    end else begin
      r_wdog <= w_wdog_nxt;
      if (w_wdog_hit) begin
        r_berr_flag <= 1'b1;
      end else if (BERR_CLR) begin
        r_berr_flag <= 1'b0;
      end
    end
  end

  // Strobe-qualified outputs drop the moment /AS negates.
  assign DSACK     = r_dsack & {2{~nAS}};
  assign BERR      = (r_wdog == TMO_M1) & ~nAS;
  assign BERR_FLAG = r_berr_flag;
  assign BUSY      = (r_state != S_IDLE);

endmodule

// File: tb/tb_cycle_term.sv
// tb_cycle_term: directed and randomized checks of cycle_term against a
// cycle-level behavioural model of the termination and watchdog rules.
module tb_cycle_term;

  localparam int          NCHAN       = 4;
  localparam int          WAIT_W      = 4;
  localparam int          BERR_W      = 7;
  localparam int          BERR_TMO    = 64;
  // ch3: wait 2, port 00; ch2: wait 3, port 10; ch1: wait 5, port 11; ch0: wait 0, port 01, needs DS
  localparam logic [15:0] CH_WAITS    = 16'h2350;
  localparam logic [7:0]  CH_PORT     = 8'b00_10_11_01;
  localparam logic [3:0]  CH_NEEDS_DS = 4'b0001;

  // Model tables written out independently of the packed parameters.
  int         wait_of [NCHAN] = '{0, 5, 3, 2};
  logic [1:0] port_of [NCHAN] = '{2'b01, 2'b11, 2'b10, 2'b00};
  bit         ds_of   [NCHAN] = '{1'b1, 1'b0, 1'b0, 1'b0};

  logic             clk = 1'b0;
  logic             rst_n;
  logic             nAS;
  logic             nDS;
  logic [NCHAN-1:0] nSEL;
  logic             STERM_IN;
  logic             BERR_CLR;
  logic [1:0]       DSACK;
  logic             BERR;
  logic             BERR_FLAG;
  logic             BUSY;

  int checks = 0;
  int errors = 0;

  // Model state: an active cycle, its channel, edges left until acknowledge.
  bit m_active;
  bit m_acked;
  int m_ch;
  int m_left;
  int m_wd;
  bit m_flag;

  cycle_term #(
    .NCHAN(NCHAN), .WAIT_W(WAIT_W), .CH_WAITS(CH_WAITS), .CH_PORT(CH_PORT),
    .CH_NEEDS_DS(CH_NEEDS_DS), .BERR_W(BERR_W), .BERR_TMO(BERR_TMO)
  ) dut (
    .CPU_CLK(clk), .nRST(rst_n), .nAS(nAS), .nDS(nDS), .nSEL(nSEL),
    .STERM_IN(STERM_IN), .BERR_CLR(BERR_CLR), .DSACK(DSACK), .BERR(BERR),
    .BERR_FLAG(BERR_FLAG), .BUSY(BUSY)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_active = 1'b0;
    m_acked  = 1'b0;
    m_ch     = 0;
    m_left   = 0;
    m_wd     = 0;
    m_flag   = 1'b0;
  endtask

  // Advance the model by one rising edge using the inputs seen at that edge.
  task automatic model_edge();
    bit hold;
    bit reached;
    int c;
    hold    = (m_active && m_acked && (port_of[m_ch] != 2'b00)) || STERM_IN;
    reached = 1'b0;
    if (nAS) begin
      m_wd = 0;
    end else if (!hold && (m_wd < BERR_TMO - 1)) begin
      m_wd++;
      reached = (m_wd == BERR_TMO - 1);
    end
    if (reached)       m_flag = 1'b1;
    else if (BERR_CLR) m_flag = 1'b0;

    if (m_active) begin
      if (nAS) begin
        m_active = 1'b0;
        m_acked  = 1'b0;
      end else if (!m_acked) begin
        m_left--;
        if (m_left == 0) m_acked = 1'b1;
      end
    end else if (!nAS) begin
      c = -1;
      for (int i = NCHAN - 1; i >= 0; i--) if (!nSEL[i]) c = i;
      if (c >= 0 && !(ds_of[c] && nDS)) begin
        m_active = 1'b1;
        m_ch     = c;
        m_left   = wait_of[c] + 1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [1:0] e_dsack;
    e_dsack = (m_active && m_acked && !nAS) ? port_of[m_ch] : 2'b00;
    check({tag, ".dsack"}, 32'(DSACK), 32'(e_dsack));
    check({tag, ".berr"},  32'(BERR),  32'((m_wd == BERR_TMO - 1) && !nAS));
    check({tag, ".flag"},  32'(BERR_FLAG), 32'(m_flag));
    check({tag, ".busy"},  32'(BUSY),  32'(m_active));
  endtask

  // One rising edge: update the model, sample 1 time unit later, return at the falling edge.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    nAS      = 1'b1;
    nDS      = 1'b1;
    nSEL     = '1;
    STERM_IN = 1'b0;
    BERR_CLR = 1'b0;
  endtask

  initial begin
    int len;
    rst_n = 1'b0;
    idle_inputs();
    model_reset();
    #3;
    check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;
    tick("idle");

    // Channel 2, three wait states: acknowledge at the fourth edge after capture.
    nAS = 1'b0; nDS = 1'b0; nSEL = 4'b1011;
    for (int e = 0; e < 4; e++) tick("ch2_wait");
    check("ch2_pre_ack", 32'(DSACK), 32'(2'b00));
    tick("ch2_ack");
    check("ch2_ack_const", 32'(DSACK), 32'(2'b10));
    nAS = 1'b1; nDS = 1'b1; nSEL = '1;
    #1 check_all("ch2_as_up");
    check("ch2_drop_const", 32'(DSACK), 32'(2'b00));
    tick("ch2_end");
    check("ch2_busy_end", 32'(BUSY), 32'(1'b0));

    // Priority and DS gating: channel 0 wins but waits for /DS.
    nAS = 1'b0; nDS = 1'b1; nSEL = 4'b1100;
    tick("ds_gate0");
    tick("ds_gate1");
    check("ds_gate_busy", 32'(BUSY), 32'(1'b0));
    nDS = 1'b0;
    tick("ds_capture");
    tick("ds_ack");
    check("ds_ack_const", 32'(DSACK), 32'(2'b01));
    nAS = 1'b1; nDS = 1'b1; nSEL = '1;
    tick("ds_end");

    // Abort while the channel 2 counter still holds 2, then a full retry.
    nAS = 1'b0; nDS = 1'b0; nSEL = 4'b1011;
    tick("abort_e0");
    tick("abort_e1");
    nAS = 1'b1; nSEL = '1;
    tick("abort_e2");
    check("abort_idle", 32'(BUSY), 32'(1'b0));
    nAS = 1'b0; nSEL = 4'b1011;
    for (int e = 0; e < 4; e++) tick("retry_wait");
    tick("retry_ack");
    check("retry_ack_const", 32'(DSACK), 32'(2'b10));
    nAS = 1'b1; nDS = 1'b1; nSEL = '1;
    tick("retry_end");

    // Port 00 slot: the watchdog ends the cycle after 63 edges.
    nAS = 1'b0; nSEL = 4'b0111;
    for (int e = 0; e < BERR_TMO - 2; e++) tick("wd_count");
    check("wd_pre_berr", 32'(BERR), 32'(1'b0));
    tick("wd_hit");
    check("wd_berr_const", 32'(BERR), 32'(1'b1));
    check("wd_flag_const", 32'(BERR_FLAG), 32'(1'b1));
    nAS = 1'b1; nSEL = '1;
    #1 check_all("wd_as_up");
    tick("wd_release");
    tick("wd_idle");
    check("wd_flag_sticky", 32'(BERR_FLAG), 32'(1'b1));
    BERR_CLR = 1'b1;
    tick("wd_clr");
    check("wd_flag_cleared", 32'(BERR_FLAG), 32'(1'b0));
    BERR_CLR = 1'b0;

    // Asynchronous reset in the middle of a channel 1 count.
    nAS = 1'b0; nDS = 1'b0; nSEL = 4'b1101;
    tick("rst_cap");
    tick("rst_count");
    #2 rst_n = 1'b0;
    model_reset();
    #1 check_all("rst_async");
    check("rst_busy_const", 32'(BUSY), 32'(1'b0));
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    tick("rst_first_edge");
    check("rst_no_ack", 32'(DSACK), 32'(2'b00));
    nAS = 1'b1; nDS = 1'b1; nSEL = '1;
    tick("rst_end");

    // STERM cycle with no select: watchdog must stay quiet.
    nAS = 1'b0; STERM_IN = 1'b1;
    for (int e = 0; e < 100; e++) tick("sterm");
    check("sterm_berr", 32'(BERR), 32'(1'b0));
    check("sterm_flag", 32'(BERR_FLAG), 32'(1'b0));
    nAS = 1'b1; STERM_IN = 1'b0;
    tick("sterm_end");

    // Randomized bus traffic: strobe-low segments of random length.
    for (int seg = 0; seg < 150; seg++) begin
      len  = $urandom_range(1, 70);
      nAS  = 1'b0;
      nSEL = 4'($urandom);
      for (int e = 0; e < len; e++) begin
        nDS      = 1'($urandom_range(0, 1));
        STERM_IN = ($urandom_range(0, 7) == 0);
        BERR_CLR = ($urandom_range(0, 15) == 0);
        if ($urandom_range(0, 9) == 0) nSEL = 4'($urandom);
        #1 check_all("rnd_comb");
        tick("rnd");
      end
      nAS = 1'b1;
      STERM_IN = 1'b0;
      BERR_CLR = ($urandom_range(0, 3) == 0);
      #1 check_all("rnd_as_up");
      for (int e = 0; e < int'($urandom_range(1, 2)); e++) tick("rnd_gap");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
